// File: rtl/fp_norm_round_pkg.sv
// Shared FP32 constants, mantissa bit indices and packed result layout
// for the add/sub normalize-and-round stage.
package fp_norm_round_pkg;

  localparam int unsigned FP_EXP_W   = 8;
  localparam int unsigned FP_FRAC_W  = 23;
  localparam int unsigned EXP_BIAS   = 127;
  localparam int unsigned EXP_MAX    = 255;

  // Unnormalized mantissa: carry, hidden, fraction, G, R, S
  localparam int unsigned FP_MANT_W  = FP_FRAC_W + 5;
  localparam int unsigned CARRY_BIT  = FP_MANT_W - 1;
  localparam int unsigned HIDDEN_BIT = FP_MANT_W - 2;
  localparam int unsigned FRAC_LSB   = 3;
  localparam int unsigned G_BIT      = 2;
  localparam int unsigned R_BIT      = 1;
  localparam int unsigned S_BIT      = 0;

  localparam int unsigned LZC_W      = 32;
  localparam int unsigned LZC_CNT_W  = 5;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_norm_round_if.sv
// Upstream operand bus and downstream result bus of the normalize/round stage.
interface fp_norm_round_if #(
  parameter int unsigned EXP_W  = fp_norm_round_pkg::FP_EXP_W,
  parameter int unsigned FRAC_W = fp_norm_round_pkg::FP_FRAC_W
);
  localparam int unsigned MANT_W = FRAC_W + 5;
  localparam int unsigned RES_W  = 1 + EXP_W + FRAC_W;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_result;
  logic              out_ovf;
  logic              out_unf;
  logic              out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_result, out_ovf, out_unf, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_result, out_ovf, out_unf, out_inexact
  );

endinterface

// File: rtl/fp_norm_round_lzc.sv
// 32-bit leading-zero counter; count is meaningful only when valid_c_o is set.
module lzc_32
  import fp_norm_round_pkg::*;
(
  input  logic [LZC_W-1:0]     a_i,
  output logic [LZC_CNT_W-1:0] cnt_c_o,
  output logic                 valid_c_o
);

  // Scan upward so the most significant set bit wins
  always_comb begin
    cnt_c_o   = '0;
    valid_c_o = 1'b0;
    for (int i = 0; i < LZC_W; i++) begin
      if (a_i[i]) begin
        cnt_c_o   = LZC_CNT_W'(LZC_W - 1 - i);
        valid_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// Two-stage normalize (LZC / carry shift) and round-to-nearest-even pack
// for the FP32 add/sub datapath, with valid/ready flow control.
module fp_norm_round #(
  parameter int unsigned EXP_W  = fp_norm_round_pkg::FP_EXP_W,
  parameter int unsigned FRAC_W = fp_norm_round_pkg::FP_FRAC_W
) (
  input logic            clk,
  input logic            rst_n,
  fp_norm_round_if.slave bus
);
  import fp_norm_round_pkg::*;

  localparam int unsigned M_W      = FRAC_W + 5;
  localparam int unsigned CARRY    = M_W - 1;
  localparam int unsigned HIDDEN   = M_W - 2;
  localparam int unsigned EXPS_W   = EXP_W + 2;
  localparam int unsigned RES_W    = 1 + EXP_W + FRAC_W;
  localparam int unsigned EXP_ALL1 = (1 << EXP_W) - 1;

  // Normalized operand; carry bit is always clear after stage 1
  typedef struct packed {
    logic              sign;
    logic [EXPS_W-1:0] exp;
    logic [M_W-2:0]    mant;
  } s1_t;

  s1_t                  s1_d, s1_q;
  logic                 s1_valid_q;
  logic                 out_valid_q;
  logic [RES_W-1:0]     res_d, res_q;
  logic                 ovf_d, ovf_q;
  logic                 unf_d, unf_q;
  logic                 inex_d, inex_q;
  logic                 s1_en, s2_en;

  logic [LZC_W-1:0]     lzc_in;
  logic [LZC_CNT_W-1:0] lz;
  logic                 lz_v;

  logic [M_W-2:0]       m;
  logic                 g, r, s, lsb, rnd_up, frac_co;
  logic [FRAC_W-1:0]    frac_r;
  logic [EXPS_W-1:0]    exp_r;

  assign s2_en        = !out_valid_q | bus.out_ready;
  assign s1_en        = !s1_valid_q | s2_en;
  assign bus.in_ready = s1_en;

  assign lzc_in = {bus.in_mant[HIDDEN:0], {(LZC_W - HIDDEN - 1){1'b0}}};

  lzc_32 u_lzc (
    .a_i       (lzc_in),
    .cnt_c_o   (lz),
    .valid_c_o (lz_v)
  );

  // Stage 1: right shift on carry-out (folding the dropped bit into S), else left-normalize
  always_comb begin
    s1_d      = '0;
    s1_d.sign = bus.in_sign;
    if (bus.in_mant[CARRY]) begin
      s1_d.mant = {bus.in_mant[CARRY:R_BIT+1], bus.in_mant[R_BIT] | bus.in_mant[S_BIT]};
      s1_d.exp  = EXPS_W'(bus.in_exp) + EXPS_W'(1);
    end else if (lz_v) begin
      s1_d.mant = bus.in_mant[HIDDEN:0] << lz;
      s1_d.exp  = EXPS_W'(bus.in_exp) - EXPS_W'(lz);
    end
  end

  // Stage 2: RNE increment, then zero / overflow / flush-to-zero selection
  always_comb begin
    m      = s1_q.mant;
    g      = m[G_BIT];
    r      = m[R_BIT];
    s      = m[S_BIT];
    lsb    = m[FRAC_LSB];
    rnd_up = g & (r | s | lsb);
    {frac_co, frac_r} = {1'b0, m[HIDDEN-1:FRAC_LSB]} + (FRAC_W + 1)'(rnd_up);
    exp_r  = s1_q.exp + EXPS_W'(frac_co);
    res_d  = {s1_q.sign, exp_r[EXP_W-1:0], frac_r};
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    inex_d = g | r | s;
    if (!m[HIDDEN]) begin
      res_d  = {s1_q.sign, (RES_W - 1)'(0)};
      inex_d = 1'b0;
    end else if ($signed(exp_r) >= $signed(EXPS_W'(EXP_ALL1))) begin
      res_d  = {s1_q.sign, EXP_W'(EXP_ALL1), FRAC_W'(0)};
      ovf_d  = 1'b1;
      inex_d = 1'b1;
    end else if ($signed(exp_r) <= $signed(EXPS_W'(0))) begin
      res_d  = {s1_q.sign, (RES_W - 1)'(0)};
      unf_d  = 1'b1;
      inex_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inex_q      <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) s1_q <= s1_d;
      end
      if (s2_en) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          res_q  <= res_d;
          ovf_q  <= ovf_d;
          unf_q  <= unf_d;
          inex_q <= inex_d;
        end
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = res_q;
  assign bus.out_ovf     = ovf_q;
  assign bus.out_unf     = unf_q;
  assign bus.out_inexact = inex_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: single ops, rounding/range edges,
// backpressure ordering and asynchronous reset with both stages full.
module tb_fp_norm_round;
  import fp_norm_round_pkg::*;

  localparam logic [7:0] BIAS = 8'(EXP_BIAS);

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  fp_norm_round_if bus ();

  fp_norm_round dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, bus.out_ovf, bus.out_unf, bus.out_inexact};
  endfunction

  task automatic drive(input logic s, input logic [7:0] e, input logic [27:0] m);
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mant  = m;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_sign  = 1'b0;
    bus.in_exp   = 8'd0;
    bus.in_mant  = 28'd0;
  endtask

  // One op through an otherwise empty pipe with out_ready held high
  task automatic run_one(input string tag, input logic s, input logic [7:0] e,
                         input logic [27:0] m, input logic [31:0] res, input logic [2:0] fl);
    @(negedge clk);
    drive(s, e, m);
    check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    idle();
    check({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_res"}, bus.out_result, res);
    check({tag, "_flg"}, flags(), 32'(fl));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    #2;
    check("rst_vld", 32'(bus.out_valid), 32'd0);
    check("rst_res", bus.out_result, 32'h0000_0000);
    check("rst_flg", flags(), 32'd0);
    check("rst_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_one("carry",    1'b0, BIAS,   28'h8000000, 32'h4000_0000, 3'b000);
    run_one("cancel",   1'b0, BIAS,   28'h0000008, 32'h3400_0000, 3'b000);
    run_one("rnd_ovf",  1'b0, BIAS,   28'h7FFFFFC, 32'h4000_0000, 3'b001);
    run_one("tie_even", 1'b0, BIAS,   28'h4000004, 32'h3F80_0000, 3'b001);
    run_one("rnd_up",   1'b0, BIAS,   28'h400000C, 32'h3F80_0002, 3'b001);
    run_one("sticky",   1'b0, BIAS,   28'h8000001, 32'h4000_0000, 3'b001);
    run_one("max_exp",  1'b0, 8'd253, 28'h8000000, 32'h7F00_0000, 3'b000);
    run_one("ovf",      1'b0, 8'd254, 28'h8000000, 32'h7F80_0000, 3'b101);
    run_one("min_norm", 1'b0, 8'd24,  28'h0000008, 32'h0080_0000, 3'b000);
    run_one("unf_edge", 1'b0, 8'd23,  28'h0000008, 32'h0000_0000, 3'b011);
    run_one("unf",      1'b1, 8'd10,  28'h0000008, 32'h8000_0000, 3'b011);
    run_one("zero",     1'b0, BIAS,   28'h0000000, 32'h0000_0000, 3'b000);
    run_one("neg_zero", 1'b1, BIAS,   28'h0000000, 32'h8000_0000, 3'b000);

    // Backpressure: A, B accepted, C stalls until the output drains
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(1'b0, BIAS, 28'h8000000);
    check("bp_rdy_a", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, BIAS, 28'h0000008);
    check("bp_rdy_b", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 8'd128, 28'h7FFFFFC);
    check("bp_rdy_c", 32'(bus.in_ready), 32'd0);
    check("bp_vld_a", 32'(bus.out_valid), 32'd1);
    check("bp_res_a", bus.out_result, 32'h4000_0000);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_stall_rdy", 32'(bus.in_ready), 32'd0);
      check("bp_stall_vld", 32'(bus.out_valid), 32'd1);
      check("bp_stall_res", bus.out_result, 32'h4000_0000);
      check("bp_stall_flg", flags(), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_rdy_release", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("bp_vld_b", 32'(bus.out_valid), 32'd1);
    check("bp_res_b", bus.out_result, 32'h3400_0000);
    drive(1'b0, BIAS, 28'h4000004);
    check("bp_rdy_d", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    idle();
    check("bp_vld_c", 32'(bus.out_valid), 32'd1);
    check("bp_res_c", bus.out_result, 32'h4080_0000);
    check("bp_flg_c", flags(), 32'd1);
    @(negedge clk);
    check("bp_vld_d", 32'(bus.out_valid), 32'd1);
    check("bp_res_d", bus.out_result, 32'h3F80_0000);
    @(negedge clk);
    check("bp_drain", 32'(bus.out_valid), 32'd0);

    // Reset with both stages occupied
    bus.out_ready = 1'b0;
    drive(1'b0, BIAS, 28'h8000000);
    @(negedge clk);
    drive(1'b1, BIAS, 28'h0000008);
    @(negedge clk);
    idle();
    check("rm_full_vld", 32'(bus.out_valid), 32'd1);
    check("rm_full_rdy", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_vld", 32'(bus.out_valid), 32'd0);
    check("rm_res", bus.out_result, 32'h0000_0000);
    check("rm_flg", flags(), 32'd0);
    check("rm_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rm_dropped", 32'(bus.out_valid), 32'd0);
    run_one("post_rst", 1'b1, BIAS, 28'h4000004, 32'hBF80_0000, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
